// File: rtl/serial_frame_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
// Parity support is selected by the SERIAL_FRAME_RX_PARITY_EN macro in the top level.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic SI_IDLE_LEVEL = 1'b1;
    localparam logic STOP_LEVEL    = 1'b1;

    // Even parity: the XOR of all data bits plus the parity bit must be zero.
    function automatic logic parity_mismatch(input logic data_xor, input logic parity_bit);
        return data_xor ^ parity_bit;
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// N-bit right-shift register: the newest serial bit enters at the MSB, so the
// first bit of a frame ends up in bit 0 after N shifts.
module sipo_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         SI,
    output logic [N-1:0] q
);

    logic [N-1:0] sh_r;

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r <= '0;
        end else if (shift_en) begin
            sh_r <= {SI, sh_r[N-1:1]};
        end else begin
            sh_r <= sh_r;
        end
    end

    assign q = sh_r;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, N data bits LSB first, optional
// even-parity bit (SERIAL_FRAME_RX_PARITY_EN), stop bit; one bit per clock.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         SI,
    output logic [N-1:0] Q,
    output logic         valid,
    output logic         frame_err,
    output logic         parity_err,
    output logic         busy
);

    localparam int             CW       = $clog2(N) + 1;
    localparam logic [CW-1:0]  LAST_BIT = CW'(N - 1);

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           shift_en_s, load_s, frame_err_s, parity_err_s;
    logic [N-1:0]   sh_s;
    logic [N-1:0]   q_r;
    logic           valid_r, frame_err_r, parity_err_r;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic           par_acc_r, par_acc_s;
    logic           par_bit_r, par_bit_s;
`endif

    sipo_shift #(.N(N)) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .SI       (SI),
        .q        (sh_s)
    );

    // Next-state, counter and strobe decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shift_en_s   = 1'b0;
        load_s       = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_acc_s    = par_acc_r;
        par_bit_s    = par_bit_r;
`endif
        case (state_r)
            IDLE: begin
                if (SI != SI_IDLE_LEVEL) begin
                    state_s = DATA;
                    cnt_s   = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    par_acc_s = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                shift_en_s = 1'b1;
                cnt_s      = cnt_r + CW'(1);
`ifdef SERIAL_FRAME_RX_PARITY_EN
                par_acc_s  = par_acc_r ^ SI;
`endif
                if (cnt_r == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                    state_s = PARITY;
`else
                    state_s = STOP;
`endif
                end else begin
                    state_s = DATA;
                end
            end
`ifdef SERIAL_FRAME_RX_PARITY_EN
            PARITY: begin
                par_bit_s = SI;
                state_s   = STOP;
            end
`endif
            STOP: begin
                // A low stop bit is an error, never a new start bit.
                state_s = IDLE;
                if (SI != STOP_LEVEL) begin
                    frame_err_s = 1'b1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                end else if (parity_mismatch(par_acc_r, par_bit_r)) begin
                    parity_err_s = 1'b1;
`endif
                end else begin
                    load_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and parity registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_acc_r <= 1'b0;
            par_bit_r <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_acc_r <= par_acc_s;
            par_bit_r <= par_bit_s;
`endif
        end
    end

    // Registered word and one-cycle strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r          <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (load_s) begin
                q_r <= sh_s;
            end else begin
                q_r <= q_r;
            end
            valid_r      <= load_s;
            frame_err_r  <= frame_err_s;
            parity_err_r <= parity_err_s;
        end
    end

    assign Q          = q_r;
    assign valid      = valid_r;
    assign frame_err  = frame_err_r;
    assign parity_err = parity_err_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (N=8), randomized frames checked
// against a frame-level reference model; parity cases follow SERIAL_FRAME_RX_PARITY_EN.
module tb_serial_frame_rx;

    localparam int N = 8;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         SI;
    logic [N-1:0] Q;
    logic         valid, frame_err, parity_err, busy;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_q;

    always #5 clk = ~clk;

    serial_frame_rx #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .SI         (SI),
        .Q          (Q),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    // Drive one bit away from the edge, let the edge sample it, observe after.
    task automatic step(input logic si_v);
        @(negedge clk);
        SI = si_v;
        @(posedge clk);
        #1;
    endtask

    // Send one frame and check every cycle against the frame-level model.
    task automatic run_frame(input logic [N-1:0] data, input logic stop_v,
                             input logic par_v, input string name);
        logic bits[$];
        logic fe, pe, good;
        logic [3:0] st, exp_st;
        bits.push_back(1'b0);
        for (int i = 0; i < N; i++) bits.push_back(data[i]);
        if (PAR) bits.push_back(par_v);
        bits.push_back(stop_v);
        fe   = (stop_v == 1'b0);
        pe   = PAR && !fe && (((^data) ^ par_v) != 1'b0);
        good = !fe && !pe;
        for (int k = 0; k < bits.size(); k++) begin
            step(bits[k]);
            st = {busy, valid, frame_err, parity_err};
            if (k < bits.size() - 1) begin
                exp_st = 4'b1000;
            end else begin
                if (good) exp_q = data;
                exp_st = {1'b0, good, fe, pe};
            end
            checks++;
            if (st !== exp_st) begin
                errors++;
                $display("FAIL %s status bit %0d: got busy/valid/ferr/perr=%b expected %b",
                         name, k, st, exp_st);
            end
            checks++;
            if (Q !== exp_q) begin
                errors++;
                $display("FAIL %s Q bit %0d: got %h expected %h", name, k, Q, exp_q);
            end
        end
    endtask

    // Idle line for a number of cycles; nothing may change.
    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            checks++;
            if ({busy, valid, frame_err, parity_err} !== 4'b0000 || Q !== exp_q) begin
                errors++;
                $display("FAIL %s cycle %0d: got flags=%b Q=%h expected flags=0000 Q=%h",
                         name, i, {busy, valid, frame_err, parity_err}, Q, exp_q);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SI    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_q = '0;
        checks++;
        if ({busy, valid, frame_err, parity_err} !== 4'b0000 || Q !== 8'h00) begin
            errors++;
            $display("FAIL reset: got flags=%b Q=%h expected flags=0000 Q=00",
                     {busy, valid, frame_err, parity_err}, Q);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_idle();
        idle(20, "idle");
    endtask

    task automatic test_good_frame();
        run_frame(8'hA5, 1'b1, ^8'hA5, "good_a5");
        idle(2, "after_a5");
    endtask

    task automatic test_frame_error();
        run_frame(8'h3C, 1'b0, ^8'h3C, "frame_err_3c");
        run_frame(8'h96, 1'b1, ^8'h96, "after_ferr_96");
        idle(1, "after_96");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h01, 1'b1, ^8'h01, "b2b_01");
        run_frame(8'hFF, 1'b1, ^8'hFF, "b2b_ff");
        idle(1, "after_b2b");
    endtask

    task automatic test_reset_mid_frame();
        logic [N-1:0] d;
        d = 8'hC3;
        step(1'b0);
        for (int i = 0; i < 4; i++) step(d[i]);
        @(negedge clk);
        reset = 1'b1;
        SI    = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        exp_q = '0;
        checks++;
        if ({busy, valid, frame_err, parity_err} !== 4'b0000 || Q !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_frame: got flags=%b Q=%h expected flags=0000 Q=00",
                     {busy, valid, frame_err, parity_err}, Q);
        end
        @(negedge clk);
        reset = 1'b0;
        SI    = 1'b1;
        run_frame(8'h5A, 1'b1, ^8'h5A, "after_reset_5a");
    endtask

    task automatic test_parity();
        if (PAR) begin
            run_frame(8'h07, 1'b1, 1'b1, "parity_ok_07");
            run_frame(8'h07, 1'b1, 1'b0, "parity_bad_07");
            run_frame(8'h81, 1'b0, 1'b1, "parity_bad_and_stop0");
            idle(1, "after_parity");
        end else begin
            idle(1, "parity_disabled_idle");
        end
    endtask

    task automatic test_random();
        logic [N-1:0] d;
        logic         stop_v, par_v;
        for (int f = 0; f < 40; f++) begin
            d      = N'($urandom);
            stop_v = ($urandom_range(0, 5) != 0);
            par_v  = ($urandom_range(0, 4) == 0) ? ~(^d) : (^d);
            run_frame(d, stop_v, par_v, "random");
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3), "random_gap");
        end
    endtask

    initial begin
        SI    = 1'b1;
        reset = 1'b1;
        exp_q = '0;
        test_reset();
        test_idle();
        test_good_frame();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
